// File: rtl/pokemon_match_ctrl_if.sv
// Match-controller bus: game-logic status in, round control and display data out.
// master: the match controller. slave: game logic / display side.
interface pokemon_match_ctrl_if;
  logic        tick;
  logic        start_btn;
  logic        char_alive;
  logic        squir_alive;
  logic [31:0] health_char;
  logic [31:0] health_squir;
  logic        round_reset;
  logic        play_en;
  logic [2:0]  state;
  logic [1:0]  score_char;
  logic [1:0]  score_squir;
  logic [2:0]  round_num;
  logic [1:0]  round_winner;
  logic [1:0]  match_winner;
  logic [15:0] time_left;
  logic [1:0]  low_hp_blink;

  modport master (
    input  tick, start_btn, char_alive, squir_alive, health_char, health_squir,
    output round_reset, play_en, state, score_char, score_squir, round_num,
           round_winner, match_winner, time_left, low_hp_blink
  );

  modport slave (
    output tick, start_btn, char_alive, squir_alive, health_char, health_squir,
    input  round_reset, play_en, state, score_char, score_squir, round_num,
           round_winner, match_winner, time_left, low_hp_blink
  );
endinterface

// File: rtl/pokemon_match_ctrl.sv
// Best-of-N match sequencer: arms rounds, gates play, decides round and match
// winners, and drives the low-HP blink for the display stages.
// Optional round timer compiled in with `define POKEMON_MATCH_TIMER_EN.
module pokemon_match_ctrl #(
  parameter int unsigned ROUNDS_TO_WIN    = 2,
  parameter int unsigned KO_HOLD_TICKS    = 3000,
  parameter int unsigned ROUND_TIME_TICKS = 60000,
  parameter int unsigned LOW_HP_PCT       = 20,
  parameter int unsigned BLINK_TICKS      = 250
) (
  input logic                  clk,
  input logic                  rst,
  pokemon_match_ctrl_if.master bus
);

  localparam logic [1:0]  WinScore   = 2'(ROUNDS_TO_WIN);
  localparam logic [15:0] KoHold     = 16'(KO_HOLD_TICKS);
  localparam logic [15:0] BlinkTicks = 16'(BLINK_TICKS);
  localparam logic [31:0] LowHp      = 32'(LOW_HP_PCT);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StArm       = 3'd1,
    StPlay      = 3'd2,
    StKo        = 3'd3,
    StMatchOver = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        start_prev_q;
  logic        arm_phase_q, arm_phase_d;
  logic [1:0]  score_char_q, score_char_d;
  logic [1:0]  score_squir_q, score_squir_d;
  logic [2:0]  round_num_q, round_num_d;
  logic [1:0]  round_winner_q, round_winner_d;
  logic [1:0]  match_winner_q, match_winner_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic        start_edge;
  logic        char_low, squir_low;
`ifdef POKEMON_MATCH_TIMER_EN
  localparam logic [15:0] RoundTime = 16'(ROUND_TIME_TICKS);
  logic [15:0] time_left_q, time_left_d;
`endif

  // start_prev powers up high so a button held through reset needs a fresh press
  assign start_edge = bus.start_btn & ~start_prev_q;

  // Next-state, scoring and counter logic
  always_comb begin
    state_d        = state_q;
    arm_phase_d    = arm_phase_q;
    score_char_d   = score_char_q;
    score_squir_d  = score_squir_q;
    round_num_d    = round_num_q;
    round_winner_d = round_winner_q;
    match_winner_d = match_winner_q;
    tick_cnt_d     = tick_cnt_q;
    blink_cnt_d    = blink_cnt_q;
    blink_phase_d  = blink_phase_q;
`ifdef POKEMON_MATCH_TIMER_EN
    time_left_d    = time_left_q;
`endif

    unique case (state_q)
      StIdle, StMatchOver: begin
        if (start_edge) begin
          score_char_d   = 2'd0;
          score_squir_d  = 2'd0;
          round_winner_d = 2'b00;
          match_winner_d = 2'b00;
          round_num_d    = 3'd1;
          state_d        = StArm;
        end
      end
      StArm: begin
        // Phase 0 pulses round_reset; phase 1 lets the alive flags reassert
        if (!arm_phase_q) begin
          arm_phase_d = 1'b1;
`ifdef POKEMON_MATCH_TIMER_EN
          time_left_d = RoundTime;
`endif
        end else begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (!bus.char_alive && !bus.squir_alive) begin
          round_winner_d = 2'b11;
          state_d        = StKo;
        end else if (!bus.char_alive) begin
          round_winner_d = 2'b10;
          if (score_squir_q < WinScore) score_squir_d = score_squir_q + 2'd1;
          state_d = StKo;
        end else if (!bus.squir_alive) begin
          round_winner_d = 2'b01;
          if (score_char_q < WinScore) score_char_d = score_char_q + 2'd1;
          state_d = StKo;
`ifdef POKEMON_MATCH_TIMER_EN
        end else if (time_left_q == 16'd0) begin
          if (bus.health_char > bus.health_squir) begin
            round_winner_d = 2'b01;
            if (score_char_q < WinScore) score_char_d = score_char_q + 2'd1;
          end else if (bus.health_squir > bus.health_char) begin
            round_winner_d = 2'b10;
            if (score_squir_q < WinScore) score_squir_d = score_squir_q + 2'd1;
          end else begin
            round_winner_d = 2'b11;
          end
          state_d = StKo;
`endif
        end
`ifdef POKEMON_MATCH_TIMER_EN
        if (bus.tick && time_left_q != 16'd0) time_left_d = time_left_q - 16'd1;
`endif
      end
      StKo: begin
        if (bus.tick) begin
          tick_cnt_d = tick_cnt_q + 16'd1;
          if (tick_cnt_d >= KoHold) begin
            if (score_char_q == WinScore || score_squir_q == WinScore) begin
              match_winner_d = (score_char_q == WinScore) ? 2'b01 : 2'b10;
              state_d        = StMatchOver;
            end else begin
              if (round_num_q != 3'd7) round_num_d = round_num_q + 3'd1;
              state_d = StArm;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Shared blink timebase runs only while in PLAY
    if (state_q == StPlay) begin
      if (bus.tick) begin
        if (blink_cnt_q + 16'd1 >= BlinkTicks) begin
          blink_cnt_d   = 16'd0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 16'd1;
        end
      end
    end else begin
      blink_cnt_d   = 16'd0;
      blink_phase_d = 1'b0;
    end

    // Every state entry restarts the per-state counters
    if (state_d != state_q) begin
      tick_cnt_d    = 16'd0;
      arm_phase_d   = 1'b0;
      blink_cnt_d   = 16'd0;
      blink_phase_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      start_prev_q   <= 1'b1;
      arm_phase_q    <= 1'b0;
      score_char_q   <= 2'd0;
      score_squir_q  <= 2'd0;
      round_num_q    <= 3'd0;
      round_winner_q <= 2'b00;
      match_winner_q <= 2'b00;
      tick_cnt_q     <= 16'd0;
      blink_cnt_q    <= 16'd0;
      blink_phase_q  <= 1'b0;
`ifdef POKEMON_MATCH_TIMER_EN
      time_left_q    <= 16'd0;
`endif
    end else begin
      state_q        <= state_d;
      start_prev_q   <= bus.start_btn;
      arm_phase_q    <= arm_phase_d;
      score_char_q   <= score_char_d;
      score_squir_q  <= score_squir_d;
      round_num_q    <= round_num_d;
      round_winner_q <= round_winner_d;
      match_winner_q <= match_winner_d;
      tick_cnt_q     <= tick_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
`ifdef POKEMON_MATCH_TIMER_EN
      time_left_q    <= time_left_d;
`endif
    end
  end

  // Output decode
  always_comb begin
    char_low  = (bus.health_char <= LowHp) && (bus.health_char != 32'd0);
    squir_low = (bus.health_squir <= LowHp) && (bus.health_squir != 32'd0);
    bus.round_reset  = (state_q == StArm) && !arm_phase_q;
    bus.play_en      = (state_q == StPlay);
    bus.state        = state_q;
    bus.score_char   = score_char_q;
    bus.score_squir  = score_squir_q;
    bus.round_num    = round_num_q;
    bus.round_winner = round_winner_q;
    bus.match_winner = match_winner_q;
    bus.low_hp_blink = {squir_low & blink_phase_q & bus.play_en,
                        char_low & blink_phase_q & bus.play_en};
`ifdef POKEMON_MATCH_TIMER_EN
    bus.time_left    = time_left_q;
`else
    bus.time_left    = 16'd0;
`endif
  end

endmodule
